// File: rtl/fuzz_state_hasher_if.sv
// Snapshot-in / hash-out bundle for fuzz_state_hasher.
// master drives the snapshot and consumes the result; slave is the hasher.
interface fuzz_state_hasher_if;
    logic        snap_valid;
    logic        snap_ready;
    logic [31:0] pc;
    logic [31:0] next_id;
    logic [31:0] num_modules;
    logic [31:0] step_count;
    logic [63:0] mu_discovery;
    logic [63:0] mu_execution;
    logic [63:0] pmask0;
    logic [63:0] pmask1;
    logic [31:0] dmem0;
    logic [31:0] dmem1;
    logic        hash_valid;
    logic        hash_ready;
    logic [255:0] final_hash;
    logic [63:0] mu_total;
    logic        mu_ovf;
    logic        busy;

    modport master (
        output snap_valid, pc, next_id, num_modules, step_count,
               mu_discovery, mu_execution, pmask0, pmask1, dmem0, dmem1,
               hash_ready,
        input  snap_ready, hash_valid, final_hash, mu_total, mu_ovf, busy
    );

    modport slave (
        input  snap_valid, pc, next_id, num_modules, step_count,
               mu_discovery, mu_execution, pmask0, pmask1, dmem0, dmem1,
               hash_ready,
        output snap_ready, hash_valid, final_hash, mu_total, mu_ovf, busy
    );
endinterface

// File: rtl/fuzz_state_hasher.sv
// End-of-run state hasher: captures a HALT snapshot, xorshift-mixes eight
// 32-bit lanes LANES_PER_CYCLE at a time, and holds the digest until taken.
module fuzz_state_hasher #(
    parameter int LANES_PER_CYCLE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    fuzz_state_hasher_if.slave  bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MIX  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0][31:0]  lane_q, lane_d;
    logic [63:0]       mu_total_q, mu_total_d;
    logic              mu_ovf_q, mu_ovf_d;

    logic [64:0]       mu_sum;
    logic [3:0]        cnt_end;
    logic [7:0][31:0]  raw_lanes;
    logic              unused_pmask_hi;

    function automatic logic [31:0] mix32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // The 65-bit sum gives the wrapped mu_total and its carry in one adder.
    assign mu_sum  = {1'b0, bus.mu_discovery} + {1'b0, bus.mu_execution};
    assign cnt_end = cnt_q + 4'(LANES_PER_CYCLE);

    assign raw_lanes[0] = bus.pc ^ bus.next_id;
    assign raw_lanes[1] = bus.num_modules ^ bus.step_count;
    assign raw_lanes[2] = bus.mu_discovery[31:0] ^ bus.mu_execution[31:0];
    assign raw_lanes[3] = mu_sum[31:0];
    assign raw_lanes[4] = bus.pmask0[31:0];
    assign raw_lanes[5] = bus.pmask1[31:0];
    assign raw_lanes[6] = bus.dmem0;
    assign raw_lanes[7] = bus.dmem1;

    assign unused_pmask_hi = ^{bus.pmask0[63:32], bus.pmask1[63:32]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lane_d     = lane_q;
        mu_total_d = mu_total_q;
        mu_ovf_d   = mu_ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.snap_valid) begin
                    lane_d     = raw_lanes;
                    mu_total_d = mu_sum[63:0];
                    mu_ovf_d   = mu_sum[64];
                    cnt_d      = 4'd0;
                    state_d    = MIX;
                end
            end
            MIX: begin
                // Lanes are mixed in place, so the window [cnt, cnt_end) is the active group.
                for (int i = 0; i < 8; i++) begin
                    if ((4'(i) >= cnt_q) && (4'(i) < cnt_end)) begin
                        lane_d[i] = mix32(lane_q[i]);
                    end
                end
                cnt_d = cnt_end;
                if (cnt_end >= 4'd8) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.hash_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            lane_q     <= '0;
            mu_total_q <= 64'd0;
            mu_ovf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lane_q     <= lane_d;
            mu_total_q <= mu_total_d;
            mu_ovf_q   <= mu_ovf_d;
        end
    end

    assign bus.snap_ready = (state_q == IDLE);
    assign bus.hash_valid = (state_q == DONE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.final_hash = lane_q;
    assign bus.mu_total   = mu_total_q;
    assign bus.mu_ovf     = mu_ovf_q;

endmodule
